// File: rtl/seven_seg_pkg.sv
// Shared constants, glyph table and display-buffer type for the seven-segment scan controller.
// Buffer fields are sized for the largest supported build (16 digits, 8-bit brightness).
package seven_seg_pkg;

  localparam int MAX_DIGITS   = 16;
  localparam int MAX_BRIGHT_W = 8;
  localparam int IDX_W        = 4;
  localparam int SEG_W        = 7;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  // Entry 15 first: F, E, d, C, b, A, 9 .. 0
  localparam logic [15:0][SEG_W-1:0] HEX_SEG = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  typedef struct packed {
    logic [MAX_DIGITS-1:0][3:0]       hex;
    logic [MAX_DIGITS-1:0][SEG_W-1:0] raw;
    logic [MAX_DIGITS-1:0]            raw_mask;
    logic [MAX_DIGITS-1:0]            dp;
    logic [MAX_DIGITS-1:0]            blank;
    logic [MAX_BRIGHT_W-1:0]          bright;
  } disp_buf_t;

  function automatic logic [SEG_W-1:0] hex_to_seg(input logic [3:0] nib);
    return HEX_SEG[nib];
  endfunction

endpackage

// File: rtl/seven_seg_decode.sv
// Hex nibble to active-high seven-segment pattern (bit 0 = A).
// Latency: combinational. Backpressure: none.
// Stateless; output follows input.
module seven_seg_decode
  import seven_seg_pkg::*;
(
  input  logic [3:0]       hex,
  output logic [SEG_W-1:0] seg
);

  assign seg = hex_to_seg(hex);

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Multiplexed seven-segment scanner with PWM brightness, anti-ghost blank cycle and frame-committed double buffer.
// Latency: outputs registered, 1 cycle behind the scan state. Backpressure: none, upd is accepted every cycle.
// Updates land in a pending buffer and become active only at the frame boundary.
module seven_seg_scan_ctrl
  import seven_seg_pkg::*;
#(
  parameter int N_DIGITS    = 8,
  parameter int SCAN_DIV    = 2048,
  parameter int BRIGHT_W    = 4,
  parameter bit SEG_ACT_LOW = 1'b1,
  parameter bit EN_ACT_LOW  = 1'b1
) (
  input  logic                      clk_sys,
  input  logic                      rst_sys,
  input  logic                      upd,
  input  logic [4*N_DIGITS-1:0]     hex_in,
  input  logic [7*N_DIGITS-1:0]     raw_in,
  input  logic [N_DIGITS-1:0]       raw_mask,
  input  logic [N_DIGITS-1:0]       dp_mask,
  input  logic [N_DIGITS-1:0]       blank_mask,
  input  logic [BRIGHT_W-1:0]       bright,
  output logic [N_DIGITS-1:0]       LEDen,
  output logic [SEG_W-1:0]          seg,
  output logic                      LEDDP,
  output logic                      frame_done
);

  localparam int SUB   = SCAN_DIV >> BRIGHT_W;
  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  if (N_DIGITS < 1 || N_DIGITS > MAX_DIGITS) begin : g_bad_digits
    $error("seven_seg_scan_ctrl: N_DIGITS out of range 1..16");
  end
  if (BRIGHT_W < 1 || BRIGHT_W > MAX_BRIGHT_W) begin : g_bad_bright
    $error("seven_seg_scan_ctrl: BRIGHT_W out of range 1..8");
  end
  if (SCAN_DIV < (1 << BRIGHT_W) || (SCAN_DIV % (1 << BRIGHT_W)) != 0) begin : g_bad_div
    $error("seven_seg_scan_ctrl: SCAN_DIV must be a multiple of 2**BRIGHT_W");
  end

  logic [CNT_W-1:0]    cnt;
  logic [IDX_W-1:0]    idx;
  logic                pend_valid;
  disp_buf_t           pend_buf;
  disp_buf_t           act_buf;
  disp_buf_t           in_buf;

  logic                cnt_wrap;
  logic                boundary;
  logic [CNT_W-1:0]    sub_slot;
  logic                digit_on;
  logic [SEG_W-1:0]    dec_seg;
  logic [SEG_W-1:0]    seg_src;
  logic [N_DIGITS-1:0] en_vec;

  always_comb begin
    in_buf = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      in_buf.hex[i] = hex_in[4*i +: 4];
      in_buf.raw[i] = raw_in[7*i +: 7];
    end
    in_buf.raw_mask[N_DIGITS-1:0] = raw_mask;
    in_buf.dp[N_DIGITS-1:0]       = dp_mask;
    in_buf.blank[N_DIGITS-1:0]    = blank_mask;
    in_buf.bright[BRIGHT_W-1:0]   = bright;
  end

  assign cnt_wrap = (cnt == CNT_W'(SCAN_DIV - 1));
  assign boundary = cnt_wrap && (idx == IDX_W'(N_DIGITS - 1));

  seven_seg_decode u_decode (
    .hex (act_buf.hex[idx]),
    .seg (dec_seg)
  );

  // cnt==0 stays dark so the segment change never overlaps a lit digit.
  always_comb begin
    sub_slot = cnt / CNT_W'(SUB);
    digit_on = (cnt != '0) && (int'(sub_slot) < int'(act_buf.bright)) && !act_buf.blank[idx];
    seg_src  = act_buf.raw_mask[idx] ? act_buf.raw[idx] : dec_seg;
    en_vec   = digit_on ? (N_DIGITS'(1) << idx) : '0;
  end

  always_ff @(posedge clk_sys) begin
    if (rst_sys) begin
      cnt        <= '0;
      idx        <= '0;
      pend_valid <= 1'b0;
      pend_buf   <= '0;
      act_buf    <= '0;
      LEDen      <= {N_DIGITS{EN_ACT_LOW}};
      seg        <= {SEG_W{SEG_ACT_LOW}};
      LEDDP      <= SEG_ACT_LOW;
      frame_done <= 1'b0;
    end else begin
      cnt <= cnt_wrap ? '0 : cnt + CNT_W'(1);
      if (cnt_wrap) begin
        idx <= boundary ? '0 : idx + IDX_W'(1);
      end

      // An upd landing on the boundary itself bypasses pending and wins.
      if (boundary) begin
        pend_valid <= 1'b0;
        if (upd) begin
          act_buf <= in_buf;
        end else if (pend_valid) begin
          act_buf <= pend_buf;
        end
      end else if (upd) begin
        pend_buf   <= in_buf;
        pend_valid <= 1'b1;
      end

      LEDen      <= EN_ACT_LOW ? ~en_vec : en_vec;
      seg        <= SEG_ACT_LOW ? ~seg_src : seg_src;
      LEDDP      <= SEG_ACT_LOW ^ (digit_on & act_buf.dp[idx]);
      frame_done <= boundary;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed and random checks of seven_seg_scan_ctrl against a frame-time reference model.
module tb_seven_seg_scan_ctrl;

  localparam int N     = 4;
  localparam int SD    = 32;
  localparam int BW    = 2;
  localparam int SUBL  = 8;
  localparam int FRAME = N * SD;

  logic        clk_sys = 1'b0;
  logic        rst_sys = 1'b1;
  logic        upd = 1'b0;
  logic [15:0] hex_in = '0;
  logic [27:0] raw_in = '0;
  logic [3:0]  raw_mask = '0;
  logic [3:0]  dp_mask = '0;
  logic [3:0]  blank_mask = '0;
  logic [1:0]  bright = '0;
  logic [3:0]  LEDen;
  logic [6:0]  seg;
  logic        LEDDP;
  logic        frame_done;

  seven_seg_scan_ctrl #(
    .N_DIGITS(N), .SCAN_DIV(SD), .BRIGHT_W(BW), .SEG_ACT_LOW(1'b0), .EN_ACT_LOW(1'b0)
  ) dut (
    .clk_sys(clk_sys), .rst_sys(rst_sys), .upd(upd), .hex_in(hex_in), .raw_in(raw_in),
    .raw_mask(raw_mask), .dp_mask(dp_mask), .blank_mask(blank_mask), .bright(bright),
    .LEDen(LEDen), .seg(seg), .LEDDP(LEDDP), .frame_done(frame_done)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct packed {
    logic [15:0] hex;
    logic [27:0] raw;
    logic [3:0]  rm;
    logic [3:0]  dp;
    logic [3:0]  bl;
    logic [1:0]  br;
  } mbuf_t;

  int    vecs = 0;
  int    fails = 0;
  int    t = 0;
  mbuf_t m_act = '0;
  mbuf_t m_pend = '0;
  bit    m_pv = 1'b0;
  logic [3:0] s_en;
  logic [6:0] s_seg;
  logic       s_dp;
  logic       s_fd;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
      4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
      4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
      4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
    endcase
  endfunction

  function automatic mbuf_t cap();
    mbuf_t b;
    b.hex = hex_in; b.raw = raw_in; b.rm = raw_mask;
    b.dp = dp_mask; b.bl = blank_mask; b.br = bright;
    return b;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: predict outputs from the model's pre-edge view, advance the model, compare.
  task automatic tick();
    int pos, dig;
    logic on;
    logic [3:0] en_e;
    logic [6:0] seg_e;
    logic dp_e, fd_e;
    pos  = t % SD;
    dig  = (t / SD) % N;
    on   = (pos != 0) && (pos < int'(m_act.br) * SUBL) && !m_act.bl[dig];
    seg_e = m_act.rm[dig] ? m_act.raw[7*dig +: 7] : glyph(m_act.hex[4*dig +: 4]);
    en_e = on ? (4'b0001 << dig) : 4'b0000;
    dp_e = on & m_act.dp[dig];
    fd_e = ((t % FRAME) == FRAME - 1);
    if (rst_sys) begin
      en_e = '0; seg_e = '0; dp_e = 1'b0; fd_e = 1'b0;
    end
    @(posedge clk_sys);
    if (rst_sys) begin
      t = 0; m_act = '0; m_pend = '0; m_pv = 1'b0;
    end else begin
      if ((t % FRAME) == FRAME - 1) begin
        if (upd) m_act = cap();
        else if (m_pv) m_act = m_pend;
        m_pv = 1'b0;
      end else if (upd) begin
        m_pend = cap();
        m_pv = 1'b1;
      end
      t++;
    end
    #1;
    s_en = LEDen; s_seg = seg; s_dp = LEDDP; s_fd = frame_done;
    chk("ledenable", {28'd0, s_en}, {28'd0, en_e});
    chk("segments", {25'd0, s_seg}, {25'd0, seg_e});
    chk("decpoint", {31'd0, s_dp}, {31'd0, dp_e});
    chk("framedone", {31'd0, s_fd}, {31'd0, fd_e});
  endtask

  task automatic wait_frame();
    for (int i = 0; i < 3 * FRAME; i++) begin
      tick();
      if (s_fd) break;
    end
    chk("frame_seen", {31'd0, s_fd}, 32'd1);
  endtask

  task automatic pulse_upd();
    upd = 1'b1;
    tick();
    upd = 1'b0;
  endtask

  initial begin
    int k;
    int on_cnt [4];
    int dp_cnt, dp_bad, g0_bad, g1_bad, raw_bad, hits;

    // Reset, run, then reset again mid-scan.
    rst_sys = 1'b1;
    repeat (3) tick();
    rst_sys = 1'b0;
    repeat (50) tick();
    rst_sys = 1'b1;
    repeat (3) tick();
    chk("rst_leden", {28'd0, s_en}, 32'd0);
    chk("rst_seg", {25'd0, s_seg}, 32'd0);
    chk("rst_dp", {31'd0, s_dp}, 32'd0);
    chk("rst_fd", {31'd0, s_fd}, 32'd0);
    rst_sys = 1'b0;
    k = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      k++;
      if (s_fd) break;
    end
    chk("first_fd_delay", k, 32'd128);

    // Hex scan at bright=3.
    hex_in = 16'h3210; bright = 2'd3;
    pulse_upd();
    wait_frame();
    for (int d = 0; d < 4; d++) on_cnt[d] = 0;
    g0_bad = 0; g1_bad = 0;
    for (int i = 0; i < FRAME; i++) begin
      tick();
      for (int d = 0; d < 4; d++) if (s_en == (4'b0001 << d)) on_cnt[d]++;
      if (s_en == 4'b0001 && s_seg != 7'h3F) g0_bad++;
      if (s_en == 4'b0010 && s_seg != 7'h06) g1_bad++;
    end
    for (int d = 0; d < 4; d++) chk($sformatf("on_cycles_b3_d%0d", d), on_cnt[d], 32'd23);
    chk("glyph0_bad", g0_bad, 32'd0);
    chk("glyph1_bad", g1_bad, 32'd0);

    // Brightness extremes.
    bright = 2'd0;
    pulse_upd();
    wait_frame();
    hits = 0;
    for (int i = 0; i < FRAME; i++) begin tick(); if (s_en != 0) hits++; end
    chk("on_cycles_b0", hits, 32'd0);
    bright = 2'd1;
    pulse_upd();
    wait_frame();
    hits = 0;
    for (int i = 0; i < FRAME; i++) begin tick(); if (s_en != 0) hits++; end
    chk("on_cycles_b1", hits, 32'd28);

    // Tear-free update issued in slot 1, overwritten before the boundary.
    wait_frame();
    repeat (40) tick();
    hex_in = 16'h1111;
    pulse_upd();
    repeat (10) tick();
    hex_in = 16'h2222;
    pulse_upd();
    wait_frame();
    hits = 0;
    for (int i = 0; i < FRAME; i++) begin tick(); if (s_seg == 7'h5B) hits++; end
    chk("last_upd_wins", hits, FRAME);

    // upd exactly on the boundary cycle.
    for (int i = 0; i < FRAME && (t % FRAME) != FRAME - 1; i++) tick();
    hex_in = 16'h4444;
    pulse_upd();
    chk("coll_fd", {31'd0, s_fd}, 32'd1);
    chk("coll_pend_valid", {31'd0, dut.pend_valid}, 32'd0);
    tick();
    chk("coll_seg", {25'd0, s_seg}, 32'h66);

    // Raw segments, decimal point, blanking.
    hex_in = 16'h3210; bright = 2'd3;
    raw_mask = 4'b0100; raw_in = '0; raw_in[20:14] = 7'h49;
    dp_mask = 4'b0001; blank_mask = 4'b1000;
    pulse_upd();
    wait_frame();
    dp_cnt = 0; dp_bad = 0; raw_bad = 0; hits = 0;
    for (int i = 0; i < FRAME; i++) begin
      tick();
      if (s_dp) dp_cnt++;
      if (s_dp && s_en != 4'b0001) dp_bad++;
      if (s_en == 4'b0100 && s_seg != 7'h49) raw_bad++;
      if (s_en[3]) hits++;
    end
    chk("dp_cycles", dp_cnt, 32'd23);
    chk("dp_outside_d0", dp_bad, 32'd0);
    chk("raw_d2_bad", raw_bad, 32'd0);
    chk("blank_d3_on", hits, 32'd0);

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      rst_sys = ($urandom_range(0, 599) == 0);
      upd = ($urandom_range(0, 29) == 0);
      if (upd) begin
        hex_in = 16'($urandom);
        raw_in = 28'($urandom);
        raw_mask = 4'($urandom);
        dp_mask = 4'($urandom);
        blank_mask = 4'($urandom);
        bright = 2'($urandom);
      end
      tick();
    end
    rst_sys = 1'b0;
    upd = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule
